output_uart: RTL and testbench

Memory-mapped serial output peripheral on the CPU data bus, in parallel with `Memory`. It snoops CPU write cycles, captures bytes written to the output address into a FIFO, and shifts them out as 8N1 UART frames on `txd`. A status address reports FIFO and transmitter state and lets software clear the overflow counter. This makes program output visible on a single pin instead of only in simulation.

---
 rtl/output_uart_pkg.sv | 7 +
 rtl/output_uart_fifo.sv | 40 ++++
 rtl/output_uart.sv | 146 ++++++++++++++
 tb/tb_output_uart.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_uart_pkg.sv
// Shared types and default bus addresses for the serial output peripheral.
package output_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [7:0] OUT_DATA_ADDR   = 8'hFF;
  localparam logic [7:0] OUT_STATUS_ADDR = 8'hFE;
endpackage

// File: rtl/output_uart_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; head word is readable
// combinationally so a consumer can pop and use it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= din;
  end

  assign dout  = mem[rdPtr[AW-1:0]];
  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty = (wrPtr == rdPtr);
endmodule

// File: rtl/output_uart.sv
// Bus-snooping serial output: captures bytes written to DATA_ADDR and
// shifts them out as 8N1 frames on txd.
module output_uart
  import output_uart_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] DATA_ADDR    = OUT_DATA_ADDR,
  parameter logic [7:0] STATUS_ADDR  = OUT_STATUS_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] memAddress,
  input  logic [7:0] memIn,
  input  logic       memWrEnable,
  output logic [7:0] statusOut,
  output logic [7:0] dropCount,
  output logic       full,
  output logic       busy,
  output logic       txd
);
  localparam int              TW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t   state, stateNext;
  logic [TW-1:0] timer, timerNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [7:0]  shiftReg, shiftNext;
  logic        txdReg, txdNext;
  logic [7:0]  dropNext;
  logic [7:0]  fifoDout;
  logic        fifoEmpty;
  logic        doPop, doPush, wrData, wrClear, timerDone;

  assign wrData    = memWrEnable && (memAddress == DATA_ADDR);
  assign wrClear   = memWrEnable && (memAddress == STATUS_ADDR) && memIn[0];
  // A full FIFO still accepts a byte when the transmitter frees a slot on this edge.
  assign doPush    = wrData && (!full || doPop);
  assign timerDone = (timer == TIMER_LAST);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (doPush),
    .pop   (doPop),
    .din   (memIn),
    .dout  (fifoDout),
    .full  (full),
    .empty (fifoEmpty)
  );

  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    txdNext    = txdReg;
    doPop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          doPop     = 1'b1;
          stateNext = START;
          timerNext = '0;
          shiftNext = fifoDout;
          txdNext   = 1'b0;
        end
      end
      START: begin
        if (timerDone) begin
          stateNext  = DATA;
          timerNext  = '0;
          bitIdxNext = 3'd0;
          txdNext    = shiftReg[0];
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      DATA: begin
        if (timerDone) begin
          timerNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txdNext   = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = {1'b0, shiftReg[7:1]};
            txdNext    = shiftReg[1];
          end
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      STOP: begin
        if (timerDone) begin
          timerNext = '0;
          if (!fifoEmpty) begin
            doPop     = 1'b1;
            stateNext = START;
            shiftNext = fifoDout;
            txdNext   = 1'b0;
          end else begin
            stateNext = IDLE;
            txdNext   = 1'b1;
          end
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  always_comb begin
    dropNext = dropCount;
    if (wrClear)
      dropNext = 8'h00;
    else if (wrData && !doPush && (dropCount != 8'hFF))
      dropNext = dropCount + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      bitIdx    <= 3'd0;
      shiftReg  <= 8'h00;
      txdReg    <= 1'b1;
      dropCount <= 8'h00;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      txdReg    <= txdNext;
      dropCount <= dropNext;
    end
  end

  assign txd       = txdReg;
  assign busy      = (state != IDLE) || !fifoEmpty;
  assign statusOut = {5'b0, (dropCount != 8'h00), full, busy};
endmodule

// File: tb/tb_output_uart.sv
// Directed bench for output_uart: register vectors, cycle-exact frame check
// and a concurrent UART receiver that compares decoded bytes against a queue.
module tb_output_uart;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] memAddress, memIn;
  logic       memWrEnable;
  logic [7:0] statusOut, dropCount;
  logic       full, busy, txd;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit abortSeen;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       expFull;
    logic [7:0] expDrop;
    logic [7:0] expStatus;
    logic       expBusy;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         b2b;
  } exp_t;

  vec_t vecs[10];
  exp_t expQ[$];

  output_uart #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .memAddress  (memAddress),
    .memIn       (memIn),
    .memWrEnable (memWrEnable),
    .statusOut   (statusOut),
    .dropCount   (dropCount),
    .full        (full),
    .busy        (busy),
    .txd         (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!rst) abortSeen = 1'b1;
    end
  endtask

  task automatic waitIdle(input int bound, input string name);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Receiver: samples mid-bit on negedges and hands each byte to the scoreboard.
  initial begin : monitor
    int lastStart;
    int startCyc;
    logic [7:0] rx;
    logic s, stp;
    exp_t e;
    lastStart = -1000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        startCyc  = cyc;
        abortSeen = 1'b0;
        negs(2);
        s = txd;
        for (int i = 0; i < 8; i++) begin
          negs(4);
          rx[i] = txd;
        end
        negs(4);
        stp = txd;
        negs(1);
        if (!abortSeen) begin
          check("start bit", s, 0);
          check("stop bit", stp, 1);
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected frame: got %02h expected none", rx);
          end else begin
            e = expQ.pop_front();
            check("frame byte", rx, e.b);
            if (e.b2b) check("frame spacing", startCyc - lastStart, 40);
          end
          lastStart = startCyc;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [9:0] frame;
    int lows;
    rst = 1'b0;
    memWrEnable = 1'b0;
    memAddress = 8'h00;
    memIn = 8'h00;

    vecs[0] = '{1'b1, 8'hFF, 8'h10, 1'b0, 8'd0, 8'h01, 1'b1};
    vecs[1] = '{1'b1, 8'hFF, 8'h11, 1'b0, 8'd0, 8'h01, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, 8'h12, 1'b0, 8'd0, 8'h01, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 8'h13, 1'b0, 8'd0, 8'h01, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 8'h14, 1'b1, 8'd0, 8'h03, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 8'h15, 1'b1, 8'd1, 8'h07, 1'b1};
    vecs[6] = '{1'b1, 8'hFF, 8'h16, 1'b1, 8'd2, 8'h07, 1'b1};
    vecs[7] = '{1'b1, 8'hFE, 8'h02, 1'b1, 8'd2, 8'h07, 1'b1};
    vecs[8] = '{1'b1, 8'h40, 8'h55, 1'b1, 8'd2, 8'h07, 1'b1};
    vecs[9] = '{1'b1, 8'hFE, 8'h01, 1'b1, 8'd0, 8'h03, 1'b1};

    // Reset state
    repeat (2) tick();
    check("reset txd", txd, 1);
    check("reset busy", busy, 0);
    check("reset full", full, 0);
    check("reset dropCount", dropCount, 0);
    check("reset statusOut", statusOut, 8'h00);
    rst = 1'b1;
    tick();

    // Single byte, cycle-exact waveform
    expQ.push_back('{8'hA5, 1'b0});
    memWrEnable = 1'b1; memAddress = 8'hFF; memIn = 8'hA5;
    tick();
    memWrEnable = 1'b0;
    check("push busy", busy, 1);
    check("txd before start", txd, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("A5 txd cycle %0d", k), txd, frame[k/4]);
    end
    check("busy in last stop cycle", busy, 1);
    tick();
    check("busy after frame", busy, 0);
    $display("single byte A5 done, checks=%0d", checks);

    // Back-to-back frames
    expQ.push_back('{8'h01, 1'b0});
    expQ.push_back('{8'h80, 1'b1});
    memWrEnable = 1'b1; memAddress = 8'hFF; memIn = 8'h01;
    tick();
    memIn = 8'h80;
    tick();
    memWrEnable = 1'b0;
    waitIdle(200, "b2b drain");
    $display("back-to-back 01,80 done, checks=%0d", checks);

    // Overflow, control and ignored writes
    expQ.push_back('{8'h10, 1'b0});
    for (int b = 8'h11; b <= 8'h14; b++) expQ.push_back('{8'(b), 1'b1});
    for (int i = 0; i < 10; i++) begin
      memWrEnable = vecs[i].we;
      memAddress  = vecs[i].addr;
      memIn       = vecs[i].data;
      tick();
      check($sformatf("vec%0d full", i), full, vecs[i].expFull);
      check($sformatf("vec%0d dropCount", i), dropCount, vecs[i].expDrop);
      check($sformatf("vec%0d statusOut", i), statusOut, vecs[i].expStatus);
      check($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
      $display("vec%0d addr=%02h data=%02h full=%0b drop=%0d status=%02h",
               i, vecs[i].addr, vecs[i].data, full, dropCount, statusOut);
    end
    memWrEnable = 1'b0;
    waitIdle(400, "overflow drain");

    // Ignored address while idle
    memWrEnable = 1'b1; memAddress = 8'h40; memIn = 8'h77;
    tick();
    memWrEnable = 1'b0;
    check("ignored write busy", busy, 0);
    check("ignored write status", statusOut, 8'h00);
    tick();
    check("ignored write txd", txd, 1);
    $display("ignored write to 40 done, checks=%0d", checks);

    // Reset during DATA bit 3 with a second byte queued
    memWrEnable = 1'b1; memAddress = 8'hFF; memIn = 8'h3C;
    tick();
    memIn = 8'hC3;
    tick();
    memWrEnable = 1'b0;
    repeat (17) tick();
    rst = 1'b0;
    tick();
    check("abort txd", txd, 1);
    check("abort busy", busy, 0);
    check("abort full", full, 0);
    check("abort statusOut", statusOut, 8'h00);
    rst = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("no frame after abort", lows, 0);
    check("busy after abort", busy, 0);
    $display("reset mid-frame done, checks=%0d", checks);

    check("frames outstanding", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
